// File: rtl/regfile_write_arbiter.sv
// Arbitrates ALU/load write-back into one registered regfile write port and scoreboards in-flight destinations.
// Latency: 1 cycle from grant to reg_write. Backpressure: the losing requester sees ready low and must hold its request.
module regfile_write_arbiter #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  alu_valid,
    input  logic [4:0]            alu_rd,
    input  logic [DATA_WIDTH-1:0] alu_data,
    output logic                  alu_ready,
    input  logic                  mem_valid,
    input  logic [4:0]            mem_rd,
    input  logic [DATA_WIDTH-1:0] mem_data,
    output logic                  mem_ready,
    input  logic                  reserve_valid,
    input  logic [4:0]            reserve_rd,
    input  logic [4:0]            rs1,
    input  logic [4:0]            rs2,
    output logic                  hazard,
    output logic                  reg_write,
    output logic [4:0]            rd,
    output logic [DATA_WIDTH-1:0] data
);

    typedef struct packed {
        logic                  reg_write;
        logic [4:0]            rd;
        logic [DATA_WIDTH-1:0] data;
    } wb_t;

    wb_t         wb_q;
    logic        last_grant;
    logic [31:0] pending;
    logic [31:0] pending_nxt;

    logic                  alu_win;
    logic                  mem_win;
    logic                  xfer;
    logic [4:0]            win_rd;
    logic [DATA_WIDTH-1:0] win_data;

    // On contention the requester that did not win last time is served.
    assign alu_win = alu_valid && (!mem_valid || last_grant);
    assign mem_win = mem_valid && (!alu_valid || !last_grant);

    // Readies are forced low while reset is held so nothing looks granted.
    assign alu_ready = reset_n && alu_win;
    assign mem_ready = reset_n && mem_win;
    assign xfer      = alu_ready || mem_ready;
    assign win_rd    = mem_ready ? mem_rd   : alu_rd;
    assign win_data  = mem_ready ? mem_data : alu_data;

    always_comb begin
        pending_nxt = pending;
        if (xfer) begin
            pending_nxt[win_rd] = 1'b0;
        end
        // Applied after the clear so a new producer of the same register wins.
        if (reserve_valid && (reserve_rd != 5'd0)) begin
            pending_nxt[reserve_rd] = 1'b1;
        end
        pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wb_q       <= '0;
            pending    <= '0;
            last_grant <= 1'b1;
        end else begin
            pending        <= pending_nxt;
            wb_q.reg_write <= xfer && (win_rd != 5'd0);
            if (xfer) begin
                wb_q.rd    <= win_rd;
                wb_q.data  <= win_data;
                last_grant <= mem_ready;
            end
        end
    end

    // The output-stage match covers the write that the regfile has not yet committed.
    function automatic logic src_busy(input logic [4:0] s);
        return (s != 5'd0) && (pending[s] || (wb_q.reg_write && (wb_q.rd == s)));
    endfunction

    assign hazard    = src_busy(rs1) || src_busy(rs2);
    assign reg_write = wb_q.reg_write;
    assign rd        = wb_q.rd;
    assign data      = wb_q.data;

endmodule
